// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data RAM behind valid/ready request and
// response channels. Serves one access at a time, inserts WAIT_CYCLES wait
// states, supports byte-lane stores and flags misaligned/out-of-range accesses.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        req_we_i,
    input  logic [3:0]  req_wstrb_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        accept;
    logic        do_access;

    logic [31:0] addr_q;
    logic        we_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic              addr_err;
    logic [IDX_W-1:0]  idx;

    logic [31:0] mem [DEPTH_WORDS];

    // Range check uses the full 30-bit word index so high addresses never alias.
    assign addr_err = (addr_q[1:0] != 2'b00) ||
                      ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
    assign idx      = addr_q[IDX_W+1:2];

    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

    // State and wait counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, handshake outputs and access strobe.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        accept       = 1'b0;
        do_access    = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    accept  = 1'b1;
                    cnt_d   = 8'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                do_access = 1'b1;
                state_d   = S_RESP;
            end
            S_RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Capture the request fields on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wstrb_q <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q  <= req_addr_i;
            we_q    <= req_we_i;
            wstrb_q <= req_wstrb_i;
            wdata_q <= req_wdata_i;
        end
    end

    // Byte-lane RAM write during ACCESS; erroneous stores are suppressed.
    always_ff @(posedge clk) begin
        if (do_access && we_q && !addr_err) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    // Response data/error registered in ACCESS and held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (do_access) begin
            err_q   <= addr_err;
            rdata_q <= (we_q || addr_err) ? '0 : mem[idx];
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: a WAIT_CYCLES=2 instance and a
// WAIT_CYCLES=0 instance share stimulus; a word model plus a scoreboard
// queue supply expected responses.
module tb_data_mem_responder;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_we = 1'b0;
    logic [3:0]  req_wstrb = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_ready = 1'b1;

    logic        d0_req_ready, d0_resp_valid, d0_resp_err;
    logic [31:0] d0_resp_rdata;
    logic        d1_req_ready, d1_resp_valid, d1_resp_err;
    logic [31:0] d1_resp_rdata;

    logic        sel = 1'b0;
    logic        o_req_ready, o_resp_valid, o_resp_err;
    logic [31:0] o_resp_rdata;

    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    exp_t        sb[$];
    exp_t        last_exp;
    logic [31:0] model [int unsigned];

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(d0_req_ready),
        .req_addr_i(req_addr), .req_we_i(req_we),
        .req_wstrb_i(req_wstrb), .req_wdata_i(req_wdata),
        .resp_valid_o(d0_resp_valid), .resp_ready_i(resp_ready),
        .resp_rdata_o(d0_resp_rdata), .resp_err_o(d0_resp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(d1_req_ready),
        .req_addr_i(req_addr), .req_we_i(req_we),
        .req_wstrb_i(req_wstrb), .req_wdata_i(req_wdata),
        .resp_valid_o(d1_resp_valid), .resp_ready_i(resp_ready),
        .resp_rdata_o(d1_resp_rdata), .resp_err_o(d1_resp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        o_req_ready  = sel ? d1_req_ready  : d0_req_ready;
        o_resp_valid = sel ? d1_resp_valid : d0_resp_valid;
        o_resp_rdata = sel ? d1_resp_rdata : d0_resp_rdata;
        o_resp_err   = sel ? d1_resp_err   : d0_resp_err;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference behaviour: error decode, byte-lane merge, load lookup.
    task automatic model_req(input logic [31:0] addr, input logic we,
                             input logic [3:0] wstrb, input logic [31:0] wdata,
                             output exp_t e);
        int unsigned w;
        logic [31:0] v;
        w       = int'(addr >> 2);
        e.err   = (addr[1:0] != 2'b00) || (w >= 1024);
        e.rdata = 32'h0;
        if (!e.err) begin
            v = model.exists(w) ? model[w] : 32'h0;
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) v[8*b +: 8] = wdata[8*b +: 8];
                model[w] = v;
            end else begin
                e.rdata = v;
            end
        end
    endtask

    task automatic issue_req(input logic [31:0] addr, input logic we,
                             input logic [3:0] wstrb, input logic [31:0] wdata,
                             output int acc_cyc);
        exp_t e;
        int   n;
        req_valid = 1'b1; req_addr = addr; req_we = we;
        req_wstrb = wstrb; req_wdata = wdata;
        n = 0;
        while (!o_req_ready && n < 50) begin
            step(1);
            n++;
        end
        acc_cyc = cyc;
        if (!o_req_ready) begin
            tests++; fails++;
            $display("FAIL req_accept_timeout addr=%h ready=%b required=1", addr, o_req_ready);
        end else begin
            model_req(addr, we, wstrb, wdata, e);
            sb.push_back(e);
        end
        step(1);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int acc_cyc);
        int n;
        int lat;
        exp_t e;
        n = 0;
        while (!o_resp_valid && n < 50) begin
            step(1);
            n++;
        end
        tests++;
        if (!o_resp_valid) begin
            fails++;
            $display("FAIL resp_timeout resp_valid=%b required=1", o_resp_valid);
            if (sb.size() > 0) last_exp = sb.pop_front();
            return;
        end
        lat = cyc - acc_cyc;
        if (lat !== (sel ? 2 : 4)) begin
            fails++;
            $display("FAIL resp_latency got=%0d required=%0d", lat, sel ? 2 : 4);
        end
        if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_resp rdata=%h err=%b required=none", o_resp_rdata, o_resp_err);
            return;
        end
        e = sb.pop_front();
        last_exp = e;
        tests++;
        if (o_resp_rdata !== e.rdata) begin
            fails++;
            $display("FAIL resp_rdata got=%h required=%h", o_resp_rdata, e.rdata);
        end
        tests++;
        if (o_resp_err !== e.err) begin
            fails++;
            $display("FAIL resp_err got=%b required=%b", o_resp_err, e.err);
        end
    endtask

    task automatic do_req(input logic [31:0] addr, input logic we,
                          input logic [3:0] wstrb, input logic [31:0] wdata);
        int acc;
        issue_req(addr, we, wstrb, wdata, acc);
        wait_resp(acc);
        step(1);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(3);
        tests++;
        if ({d0_req_ready, d0_resp_valid, d0_resp_err} !== 3'b100 || d0_resp_rdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs ready/valid/err=%b rdata=%h required=100/00000000",
                     {d0_req_ready, d0_resp_valid, d0_resp_err}, d0_resp_rdata);
        end
        rst_n = 1'b1;
        step(3);
        tests++;
        if ({d0_req_ready, d0_resp_valid, d0_resp_err} !== 3'b100 || d0_resp_rdata !== 32'h0) begin
            fails++;
            $display("FAIL idle_outputs ready/valid/err=%b rdata=%h required=100/00000000",
                     {d0_req_ready, d0_resp_valid, d0_resp_err}, d0_resp_rdata);
        end
    endtask

    task automatic test_store_load;
        do_req(32'h10, 1'b1, 4'b1111, 32'hDEADBEEF);
        do_req(32'h10, 1'b0, 4'b0000, 32'h0);
    endtask

    task automatic test_byte_lanes;
        do_req(32'h10, 1'b1, 4'b0001, 32'h000000AA);
        do_req(32'h10, 1'b0, 4'b0000, 32'h0);
        do_req(32'h10, 1'b1, 4'b0000, 32'hFFFFFFFF);
        do_req(32'h10, 1'b0, 4'b0000, 32'h0);
        do_req(32'h10, 1'b1, 4'b1010, 32'h11223344);
        do_req(32'h10, 1'b0, 4'b0000, 32'h0);
    endtask

    task automatic test_errors;
        do_req(32'h0,        1'b1, 4'b1111, 32'h01020304);
        do_req(32'hFFC,      1'b1, 4'b1111, 32'h55667788);
        do_req(32'h12,       1'b0, 4'b0000, 32'h0);
        do_req(32'h1000,     1'b0, 4'b0000, 32'h0);
        do_req(32'hFFFFFFFC, 1'b1, 4'b1111, 32'hBADBADBA);
        do_req(32'h0,        1'b0, 4'b0000, 32'h0);
        do_req(32'hFFC,      1'b0, 4'b0000, 32'h0);
    endtask

    task automatic test_stall;
        int acc;
        resp_ready = 1'b0;
        issue_req(32'h10, 1'b0, 4'b0000, 32'h0, acc);
        wait_resp(acc);
        for (int i = 0; i < 5; i++) begin
            step(1);
            tests++;
            if (o_resp_valid !== 1'b1 || o_req_ready !== 1'b0 ||
                o_resp_rdata !== last_exp.rdata || o_resp_err !== last_exp.err) begin
                fails++;
                $display("FAIL stall_hold cycle=%0d valid=%b ready=%b rdata=%h err=%b required 1/0/%h/%b",
                         i, o_resp_valid, o_req_ready, o_resp_rdata, o_resp_err,
                         last_exp.rdata, last_exp.err);
            end
        end
        resp_ready = 1'b1;
        step(1);
        tests++;
        if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL stall_release valid=%b ready=%b required 0/1", o_resp_valid, o_req_ready);
        end
    endtask

    task automatic test_back_to_back;
        int   acc[$];
        int   n;
        exp_t e;
        req_valid = 1'b1; req_addr = 32'h10; req_we = 1'b0;
        req_wstrb = '0; req_wdata = '0;
        n = 0;
        while ((acc.size() < 4 || sb.size() > 0) && n < 200) begin
            if (o_resp_valid) begin
                e = sb.pop_front();
                tests++;
                if (o_resp_rdata !== e.rdata || o_resp_err !== e.err) begin
                    fails++;
                    $display("FAIL b2b_resp rdata=%h err=%b required %h/%b",
                             o_resp_rdata, o_resp_err, e.rdata, e.err);
                end
            end
            if (o_req_ready && req_valid) begin
                acc.push_back(cyc);
                model_req(req_addr, req_we, req_wstrb, req_wdata, e);
                sb.push_back(e);
                if (acc.size() == 4) begin
                    step(1);
                    req_valid = 1'b0;
                    n++;
                    continue;
                end
            end
            step(1);
            n++;
        end
        req_valid = 1'b0;
        tests++;
        if (acc.size() != 4 || sb.size() != 0) begin
            fails++;
            $display("FAIL b2b_count accepts=%0d pending=%0d required 4/0", acc.size(), sb.size());
        end
        for (int i = 1; i < acc.size(); i++) begin
            tests++;
            if (acc[i] - acc[i-1] != 5) begin
                fails++;
                $display("FAIL b2b_spacing idx=%0d got=%0d required=5", i, acc[i] - acc[i-1]);
            end
        end
    endtask

    task automatic test_reset_mid_wait;
        int          acc;
        int          seen;
        logic [31:0] saved;
        exp_t        e;
        do_req(32'h20, 1'b1, 4'b1111, 32'hCAFEF00D);
        saved = model[8];
        issue_req(32'h20, 1'b1, 4'b1111, 32'h12345678, acc);
        e = sb.pop_back();
        model[8] = saved;
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        #1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_resp_valid) seen++;
            step(1);
        end
        tests++;
        if (seen != 0 || o_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_drop resp_cycles=%0d ready=%b required 0/1", seen, o_req_ready);
        end
        do_req(32'h20, 1'b0, 4'b0000, 32'h0);
    endtask

    task automatic test_wait0;
        step(4);
        sel = 1'b1;
        model.delete();
        do_req(32'h40, 1'b1, 4'b1111, 32'hA5A55A5A);
        do_req(32'h40, 1'b0, 4'b0000, 32'h0);
        do_req(32'h42, 1'b0, 4'b0000, 32'h0);
        sel = 1'b0;
    endtask

    initial begin
        test_reset;
        test_store_load;
        test_byte_lanes;
        test_errors;
        test_stall;
        test_back_to_back;
        test_reset_mid_wait;
        test_wait0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
